// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential signed 32x32 multiply and 32/32 divide unit.
// One radix-2 step per cycle on operand magnitudes: shift-add for multiply
// and restoring shift-subtract for divide. The sign of the result is applied
// once, on the final step, as HI/LO are loaded. A divide by zero is flagged
// for one cycle on ErroDiv and leaves HI/LO untouched.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        MultOrDiv,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic        ErroDiv,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [4:0]  count;

  // Operation captured at acceptance. mag_m holds |A| for a multiply
  // (the value added on each step) or |B| for a divide (the divisor).
  logic        op_div;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] mag_m;

  // Working pair. Multiply: {part_hi, part_lo} is the partial product,
  // with the multiplier bits shifting out of part_lo. Divide: part_hi is
  // the partial remainder and part_lo shifts dividend bits out while
  // quotient bits shift in.
  logic [31:0] part_hi;
  logic [31:0] part_lo;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        accept;
  logic        div_zero;
  logic        last_step;

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_trial;
  logic [31:0] step_hi;
  logic [31:0] step_lo;

  logic [63:0] prod_mag;
  logic [63:0] prod_signed;
  logic [31:0] quo_signed;
  logic [31:0] rem_signed;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // The most negative value maps to 0x80000000, which is its correct
  // unsigned magnitude, so no extra bit is needed.
  assign abs_a = A[31] ? (32'd0 - A) : A;
  assign abs_b = B[31] ? (32'd0 - B) : B;

  assign last_step = (state == RUN) && (count == 5'd31);

  // Decide whether a start request in IDLE begins an operation or is a
  // divide by zero that goes straight to the error cycle.
  always_comb begin
    accept   = 1'b0;
    div_zero = 1'b0;
    if ((state == IDLE) && start) begin
      if (MultOrDiv && (B == 32'd0)) begin
        div_zero = 1'b1;
      end else begin
        accept = 1'b1;
      end
    end
  end

  // Next-state logic: DONE and ERR each last one cycle, and RUN lasts for
  // exactly 32 steps.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (div_zero) begin
          state_next = ERR;
        end else if (accept) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (count == 5'd31) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, with reset taking priority over any start request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Iteration counter: cleared on acceptance and advanced once per RUN
  // cycle. It wraps from 31 back to 0 as RUN ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 5'd0;
    end else if (accept) begin
      count <= 5'd0;
    end else if (state == RUN) begin
      count <= count + 5'd1;
    end
  end

  // Capture the operation and operand signs, so later changes on A, B or
  // MultOrDiv cannot disturb the operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_m  <= 32'd0;
    end else if (accept) begin
      op_div <= MultOrDiv;
      sign_a <= A[31];
      sign_b <= B[31];
      mag_m  <= MultOrDiv ? abs_b : abs_a;
    end
  end

  // One radix-2 step. Multiply: add the multiplicand when the low
  // multiplier bit is set, then shift the 65-bit {carry, hi, lo} right.
  // Divide: shift the next dividend bit into the remainder and keep the
  // trial subtraction only when it does not go negative. The remainder
  // stays below the divisor (at most 2^31), so the shifted value is below
  // 2^32 and bit 32 of the trial is a reliable borrow.
  always_comb begin
    mul_sum   = {1'b0, part_hi} + (part_lo[0] ? {1'b0, mag_m} : 33'd0);
    div_shift = {part_hi, part_lo[31]};
    div_trial = div_shift - {1'b0, mag_m};
    if (op_div) begin
      step_hi = div_trial[32] ? div_shift[31:0] : div_trial[31:0];
      step_lo = {part_lo[30:0], ~div_trial[32]};
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], part_lo[31:1]};
    end
  end

  // Working registers: loaded with magnitudes on acceptance, then stepped
  // once per RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      part_hi <= 32'd0;
      part_lo <= 32'd0;
    end else if (accept) begin
      part_hi <= 32'd0;
      part_lo <= MultOrDiv ? abs_a : abs_b;
    end else if (state == RUN) begin
      part_hi <= step_hi;
      part_lo <= step_lo;
    end
  end

  // Sign correction of the final step's magnitudes. The quotient is
  // negative when the operand signs differ, and the remainder follows the
  // dividend. 0x80000000 / -1 wraps naturally to 0x80000000.
  always_comb begin
    prod_mag    = {step_hi, step_lo};
    prod_signed = (sign_a ^ sign_b) ? (64'd0 - prod_mag) : prod_mag;
    quo_signed  = (sign_a ^ sign_b) ? (32'd0 - step_lo) : step_lo;
    rem_signed  = sign_a ? (32'd0 - step_hi) : step_hi;
    if (op_div) begin
      res_hi = rem_signed;
      res_lo = quo_signed;
    end else begin
      res_hi = prod_signed[63:32];
      res_lo = prod_signed[31:0];
    end
  end

  // HI/LO change only on the last RUN step (entering DONE) or on reset,
  // so a divide by zero leaves the previous result visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (last_step) begin
      HI <= res_hi;
      LO <= res_lo;
    end
  end

  assign busy    = (state == RUN) || (state == DONE);
  assign done    = (state == DONE);
  assign ErroDiv = (state == ERR);

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table-driven and random vectors for muldiv_seq. Expected
// results are queued when a start is driven and are popped when done or
// ErroDiv appears. Hand-written sequences cover ignored starts, reset
// during RUN and reset/start priority.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        MultOrDiv;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic        ErroDiv;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
  } exp_t;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
  } vec_t;

  localparam int NVEC = 16;

  vec_t        vecs [NVEC];
  exp_t        sb [$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc_now     = 0;
  int          t_accept    = 0;
  logic [31:0] last_hi     = 32'd0;
  logic [31:0] last_lo     = 32'd0;

  muldiv_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .MultOrDiv (MultOrDiv),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .ErroDiv   (ErroDiv),
    .HI        (HI),
    .LO        (LO)
  );

  // Free-running clock and cycle counter used for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cyc_now <= cyc_now + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one start pulse in the current (IDLE) cycle, then scramble the
  // operand inputs so that the result must come from captured values.
  task automatic applyStimulus(input logic op, input logic [31:0] a, input logic [31:0] b);
    MultOrDiv = op;
    A         = a;
    B         = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    t_accept  = cyc_now;
    A         = $urandom;
    B         = $urandom;
    MultOrDiv = ~op;
  endtask

  // Wait for the DUT to finish, then pop and compare the scoreboard entry.
  // Done is due in the 33rd cycle after acceptance, ErroDiv in the 1st.
  task automatic waitResult();
    exp_t e;
    int   lat;
    bit   seen;
    bit   busy_gap;
    seen     = 1'b0;
    busy_gap = 1'b0;
    lat      = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat = cyc_now - t_accept + 1;
      if (done || ErroDiv) begin
        seen = 1'b1;
      end else if (!busy) begin
        busy_gap = 1'b1;
      end
    end
    checkOutput("result_seen", 64'(seen), 64'd1);
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      if (seen) begin
        checkOutput("errodiv", 64'(ErroDiv), 64'(e.err));
        checkOutput("done", 64'(done), 64'(!e.err));
        checkOutput("busy_at_result", 64'(busy), 64'(!e.err));
        checkOutput("latency", 64'(lat), e.err ? 64'd1 : 64'd33);
        checkOutput("HI", 64'(HI), 64'(e.hi));
        checkOutput("LO", 64'(LO), 64'(e.lo));
        if (!e.err) begin
          checkOutput("busy_during_run", 64'(busy_gap), 64'd0);
        end
        @(negedge clk);
        checkOutput("pulse_end", 64'({busy, done, ErroDiv}), 64'd0);
      end
      last_hi = e.hi;
      last_lo = e.lo;
    end
  endtask

  // Count any activity over a window where nothing should happen.
  task automatic watchIdle(input string name, input int ncyc);
    int seen_any;
    seen_any = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (busy || done || ErroDiv) seen_any++;
    end
    checkOutput(name, 64'(seen_any), 64'd0);
  endtask

  // Reference model from signed 64-bit arithmetic, which truncates toward
  // zero; the remainder follows the dividend.
  function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] ph, input logic [31:0] pl);
    longint sa;
    longint sbv;
    longint p;
    longint q;
    longint r;
    exp_t   e;
    sa    = longint'($signed(a));
    sbv   = longint'($signed(b));
    e.err = 1'b0;
    if (!op) begin
      p    = sa * sbv;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.err = 1'b1;
      e.hi  = ph;
      e.lo  = pl;
    end else begin
      q    = sa / sbv;
      r    = sa % sbv;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  initial begin
    logic        rop;
    logic [31:0] ra;
    logic [31:0] rb;
    exp_t        re;

    //          op    A             B             HI            LO            err
    vecs[0]  = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[2]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{1'b1, 32'h00000005, 32'h00000002, 32'h00000001, 32'h00000002, 1'b0};
    vecs[4]  = '{1'b1, 32'h00000009, 32'h00000000, 32'h00000001, 32'h00000002, 1'b1};
    vecs[5]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[6]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[8]  = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[9]  = '{1'b1, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0};
    vecs[10] = '{1'b1, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0};
    vecs[11] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[12] = '{1'b0, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
    vecs[13] = '{1'b1, 32'h00000003, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0};
    vecs[14] = '{1'b1, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[15] = '{1'b0, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0};

    reset     = 1'b1;
    start     = 1'b0;
    MultOrDiv = 1'b0;
    A         = 32'd0;
    B         = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_flags", 64'({busy, done, ErroDiv}), 64'd0);
    checkOutput("reset_HI", 64'(HI), 64'd0);
    checkOutput("reset_LO", 64'(LO), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table vectors, issued back to back in the IDLE cycle after each result.
    for (int i = 0; i < NVEC; i++) begin
      sb.push_back('{vecs[i].hi, vecs[i].lo, vecs[i].err});
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitResult();
    end

    // Random vectors checked against the reference model; the last one is a
    // divide by zero that must keep the previous result.
    for (int i = 0; i < 8; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom;
      if (i < 3) rb = rb >> 27;
      if (rop && rb == 32'd0) rb = 32'd1;
      if (i == 7) begin
        rop = 1'b1;
        rb  = 32'd0;
      end
      re = model(rop, ra, rb, last_hi, last_lo);
      sb.push_back(re);
      applyStimulus(rop, ra, rb);
      waitResult();
    end

    // A start pulse during RUN must be ignored and not queued.
    sb.push_back('{32'h0, 32'd12, 1'b0});
    applyStimulus(1'b0, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    MultOrDiv = 1'b1;
    A         = 32'd8;
    B         = 32'd2;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitResult();
    watchIdle("ignored_start_activity", 40);

    // Reset in RUN cycle 10 aborts the operation and clears HI/LO.
    applyStimulus(1'b0, 32'd5, 32'd6);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_HI", 64'(HI), 64'd0);
    checkOutput("abort_LO", 64'(LO), 64'd0);
    watchIdle("abort_activity", 40);
    sb.push_back('{32'h0, 32'd6, 1'b0});
    applyStimulus(1'b0, 32'd2, 32'd3);
    waitResult();

    // Reset and start on the same edge: reset wins, nothing starts.
    reset     = 1'b1;
    start     = 1'b1;
    MultOrDiv = 1'b0;
    A         = 32'd9;
    B         = 32'd9;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("priority_LO", 64'(LO), 64'd0);
    watchIdle("priority_activity", 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
